relu_stream_arbiter: RTL and testbench
======================================

Name: relu_stream_arbiter

Overview:
Shares one streaming activation (ReLU) stage between NUM_CH requester streams using ready/valid on every interface. Packet-granular round-robin arbitration: a grant is held from the first beat to the beat flagged last. Each accepted beat's channel ID goes into an in-order tag FIFO. Results from the shared stage are routed back to the originating channel's response port. The block sits between the CNN layer producers and the single shared activation instance.

Parameters:
NUM_CH, 4, number of requester channels (2..8)
DATA_WIDTH, 32, data beat width
MAX_INFLIGHT, 4, tag FIFO depth, which is the maximum number of beats inside the shared stage (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_data  in  NUM_CH x DATA_WIDTH  per-channel input beat
req_valid  in  NUM_CH  per-channel beat valid
req_last  in  NUM_CH  beat is the final beat of the packet
req_ready  out  NUM_CH  per-channel beat accepted
act_in_data  out  DATA_WIDTH  beat to the shared stage
act_in_valid  out  1  valid to the shared stage
act_in_ready  in  1  shared stage ready
act_out_data  in  DATA_WIDTH  result from the shared stage
act_out_valid  in  1  result valid
act_out_ready  out  1  result accepted
rsp_data  out  DATA_WIDTH  result data, broadcast to all channels
rsp_valid  out  NUM_CH  one-hot result valid for the owning channel
rsp_ready  in  NUM_CH  per-channel result ready
busy  out  1  FSM in LOCKED or tag FIFO non-empty
grant_id  out  $clog2(NUM_CH)  currently or last granted channel
err  out  1  sticky protocol error

Behaviour:
- Reset values: FSM=IDLE, grant_id=0, last_grant=NUM_CH-1 (so channel 0 wins first), tag FIFO empty, err=0. All req_ready, act_in_valid, act_out_ready, rsp_valid and busy are 0.
- FSM states: IDLE and LOCKED.
- IDLE:
  - If any req_valid is set, pick the first set channel searching from last_grant+1, wrapping modulo NUM_CH.
  - Register the pick into grant_id and go to LOCKED.
  - This costs exactly 1 arbitration bubble cycle. No beat is accepted in IDLE.
- LOCKED, with g=grant_id:
  - act_in_data=req_data[g].
  - act_in_valid=req_valid[g] && !tag_full.
  - req_ready[g]=act_in_ready && !tag_full. All other req_ready are 0.
  - Handshake means req_valid[g] && req_ready[g]. On a handshake, push g into the tag FIFO.
  - If the handshake beat has req_last[g]=1: set last_grant<=g and go to IDLE.
  - Other channels' req_valid has no effect while LOCKED.
- Full gating: tag_full blocks the push even if a pop happens in the same cycle. There is no combinational full-to-pop path.
- Response path, with h=tag FIFO head:
  - rsp_data=act_out_data.
  - rsp_valid[h]=act_out_valid && !tag_empty. All other rsp_valid bits are 0.
  - act_out_ready=!tag_empty && rsp_ready[h].
  - Pop on act_out_valid && act_out_ready.
  - Simultaneous push and pop is legal and leaves the count unchanged.
- Protocol error: act_out_valid=1 while the tag FIFO is empty sets err. err stays set until reset. act_out_ready stays 0 in that case.
- busy = (state==LOCKED) || !tag_empty.
- Ordering: the shared stage is in-order. Results map to tags strictly FIFO. There is no latency assumption on the shared stage.
- Throughput: 1 beat/cycle within a packet. Each packet costs 1 idle cycle for arbitration.
- Reset mid-packet: all state is dropped. In-flight tags are discarded. The FSM returns to IDLE. Requesters must restart the packet.

Decomposition:
- Package relu_arb_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCKED)
  - the ch_id_t typedef, width $clog2(NUM_CH)
  - a round-robin next-grant function
- Sub-module relu_arb_tag_fifo:
  - parameterised depth and width
  - push/pop, full/empty, head output
  - flop storage, read/write pointers with an extra wrap bit

Test Plan:
- Single packet: ch1 sends 3 beats {-5, 7, 0x80000000} with last on the 3rd, and the stage models ReLU with 1-cycle latency. Expect act_in_valid first in cycle 2 after req_valid. rsp_valid=4'b0010 three times with data {0, 7, 0}. Then IDLE, busy=0, grant_id=1.
- Contention: ch0, ch2 and ch3 each send a 2-beat packet, all asserted together from reset. Expect grant order 0,2,3. Expect 1 bubble cycle between packets and no beat interleaving.
- Fairness: ch0 resends immediately after its packet while ch3 is waiting. Expect ch3 to be granted before ch0 again.
- Backpressure and full: MAX_INFLIGHT=4, stage always ready, rsp_ready[0]=0, ch0 sends an 8-beat packet. Expect exactly 4 beats accepted, then req_ready[0]=0. Release rsp_ready and expect the remaining 4 to complete in order.
- Reset mid-packet: assert rst_n low after 2 of 5 beats. Expect all outputs 0, tag FIFO empty and err=0. A fresh packet completes normally afterwards.
- Protocol error: act_out_valid=1 with no beat issued. Expect err=1 and act_out_ready=0. err stays 1 across later traffic until reset.

Source files
------------

// File: rtl/relu_arb_pkg.sv
// Shared types and the round-robin helper for the ReLU stream arbiter.
package relu_arb_pkg;

  // Widest channel ID the helper supports (NUM_CH up to 8).
  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned CH_ID_W = $clog2(MAX_CH);

  typedef logic [CH_ID_W-1:0] ch_id_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // First requesting channel after 'last', wrapping modulo num_ch.
  function automatic ch_id_t rr_next_grant(input logic [MAX_CH-1:0] req,
                                           input ch_id_t            last,
                                           input int unsigned       num_ch);
    ch_id_t      pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= num_ch; i++) begin
      idx = (32'(last) + i) % num_ch;
      if (!found && req[CH_ID_W'(idx)]) begin
        pick  = ch_id_t'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/relu_arb_tag_fifo.sv
// In-order tag FIFO: records which channel owns each beat inside the shared stage.
module relu_arb_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic [AW:0]      wptr_d, rptr_d;
  logic             do_push, do_pop;

  // Extra wrap bit distinguishes full from empty when the indices match.
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  // Qualify requests so the pointers never overrun.
  always_comb begin
    do_push = push_i && !full_o;
    do_pop  = pop_i && !empty_o;
    wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Tag storage; contents are don't-care while empty, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/relu_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one ReLU stage across NUM_CH streams.
module relu_stream_arbiter
  import relu_arb_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_last,
  output logic [NUM_CH-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]        act_in_data,
  output logic                         act_in_valid,
  input  logic                         act_in_ready,
  input  logic [DATA_WIDTH-1:0]        act_out_data,
  input  logic                         act_out_valid,
  output logic                         act_out_ready,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [NUM_CH-1:0]            rsp_valid,
  input  logic [NUM_CH-1:0]            rsp_ready,
  output logic                         busy,
  output logic [$clog2(NUM_CH)-1:0]    grant_id,
  output logic                         err
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  arb_state_e      state_q;
  logic [CH_W-1:0] grant_q;
  logic [CH_W-1:0] last_grant_q;
  logic            err_q;

  logic [DATA_WIDTH-1:0] req_words [NUM_CH];
  logic                  locked;
  logic                  req_hs;
  logic                  tag_full, tag_empty, tag_pop;
  logic [CH_W-1:0]       tag_head;

  // Unpack the flat request bus into per-channel words.
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      req_words[c] = req_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Forward path: only the granted channel sees ready, gated by tag space.
  always_comb begin
    locked       = (state_q == ARB_LOCKED);
    act_in_data  = req_words[grant_q];
    act_in_valid = locked && req_valid[grant_q] && !tag_full;
    req_ready    = '0;
    if (locked) req_ready[grant_q] = act_in_ready && !tag_full;
    req_hs       = locked && req_valid[grant_q] && act_in_ready && !tag_full;
  end

  // Return path: steer each result to the channel at the tag FIFO head.
  always_comb begin
    rsp_valid = '0;
    if (!tag_empty) rsp_valid[tag_head] = act_out_valid;
    act_out_ready = !tag_empty && rsp_ready[tag_head];
    tag_pop       = act_out_valid && act_out_ready;
  end

  assign rsp_data = act_out_data;
  assign busy     = locked || !tag_empty;
  assign grant_id = grant_q;
  assign err      = err_q;

  relu_arb_tag_fifo #(
    .DEPTH (MAX_INFLIGHT),
    .WIDTH (CH_W)
  ) u_tag_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (req_hs),
    .data_i  (grant_q),
    .pop_i   (tag_pop),
    .full_o  (tag_full),
    .empty_o (tag_empty),
    .head_o  (tag_head)
  );

  // Arbitration FSM: one bubble cycle to pick, then hold until the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|req_valid) begin
            grant_q <= CH_W'(rr_next_grant(MAX_CH'(req_valid), ch_id_t'(last_grant_q), NUM_CH));
            state_q <= ARB_LOCKED;
          end
        end
        ARB_LOCKED: begin
          if (req_hs && req_last[grant_q]) begin
            last_grant_q <= grant_q;
            state_q      <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Sticky error: a result arrived with no beat outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       err_q <= 1'b0;
    else if (act_out_valid && tag_empty) err_q <= 1'b1;
  end

endmodule

// File: tb/tb_relu_stream_arbiter.sv
// Scoreboard bench for relu_stream_arbiter with a randomized shared-stage model.
module tb_relu_stream_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int MI  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_valid, req_last, req_ready;
  logic [DW-1:0]     act_in_data;
  logic              act_in_valid, act_in_ready;
  logic [DW-1:0]     act_out_data;
  logic              act_out_valid, act_out_ready;
  logic [DW-1:0]     rsp_data;
  logic [NCH-1:0]    rsp_valid, rsp_ready;
  logic              busy;
  logic [1:0]        grant_id;
  logic              err;

  always #5 clk = ~clk;

  relu_stream_arbiter #(
    .NUM_CH       (NCH),
    .DATA_WIDTH   (DW),
    .MAX_INFLIGHT (MI)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_data      (req_data),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .act_in_data   (act_in_data),
    .act_in_valid  (act_in_valid),
    .act_in_ready  (act_in_ready),
    .act_out_data  (act_out_data),
    .act_out_valid (act_out_valid),
    .act_out_ready (act_out_ready),
    .rsp_data      (rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .busy          (busy),
    .grant_id      (grant_id),
    .err           (err)
  );

  typedef struct { logic [DW-1:0] data; logic last; } beat_t;
  typedef struct { int ch; logic [DW-1:0] data; } exp_t;

  beat_t         src_q [NCH][$];
  logic [DW-1:0] stage_q[$];
  exp_t          exp_q[$];
  int            grant_log[$];
  int            acc_cnt [NCH];
  int            rsp_cnt;
  int            n_tests = 0;
  int            n_fail  = 0;

  int            gap_pct, in_rdy_pct, out_vld_pct, rsp_rdy_pct;
  logic [NCH-1:0] rsp_block;
  logic          force_out;

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] d);
    return d[DW-1] ? '0 : d;
  endfunction

  function automatic int rr_ref(input logic [NCH-1:0] req, input int last);
    for (int k = 1; k <= NCH; k++)
      if (req[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_beat(input int ch, input logic [DW-1:0] d, input logic last);
    beat_t b;
    b.data = d;
    b.last = last;
    src_q[ch].push_back(b);
  endtask

  task automatic push_pkt(input int ch, input int len);
    for (int b = 0; b < len; b++) push_beat(ch, $urandom, b == len - 1);
  endtask

  task automatic reset_now();
    #2;
    rst_n = 1'b0;
    for (int c = 0; c < NCH; c++) src_q[c].delete();
    stage_q.delete();
    req_valid     = '0;
    act_out_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    reset_now();
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int  n = 0;
    bit  pend;
    forever begin
      pend = (stage_q.size() != 0) || (exp_q.size() != 0) || busy;
      for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) pend = 1'b1;
      if (!pend || n >= budget) break;
      @(negedge clk);
      n++;
    end
    check(name, 64'(n < budget), 64'(1));
    repeat (2) @(negedge clk);
  endtask

  task automatic check_order(input string name, input int e0, input int e1, input int e2);
    check({name, "_len"}, 64'(grant_log.size()), 64'(3));
    if (grant_log.size() == 3) begin
      check({name, "_0"}, 64'(grant_log[0]), 64'(e0));
      check({name, "_1"}, 64'(grant_log[1]), 64'(e1));
      check({name, "_2"}, 64'(grant_log[2]), 64'(e2));
    end
  endtask

  // Environment: requester drivers and the shared in-order stage.
  initial begin : driver
    logic [NCH-1:0] hs;
    logic           ain, aout;
    logic [DW-1:0]  ad;
    req_valid = '0; req_data = '0; req_last = '0; rsp_ready = '0;
    act_in_ready = 1'b0; act_out_valid = 1'b0; act_out_data = '0;
    forever begin
      @(negedge clk);
      hs   = req_valid & req_ready;
      ain  = act_in_valid && act_in_ready;
      aout = act_out_valid && act_out_ready;
      ad   = act_in_data;
      @(posedge clk);
      #1;
      if (rst_n) begin
        for (int c = 0; c < NCH; c++)
          if (hs[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
        if (aout && stage_q.size() > 0) void'(stage_q.pop_front());
        if (ain) stage_q.push_back(relu(ad));
      end
      for (int c = 0; c < NCH; c++) begin
        if (src_q[c].size() > 0 &&
            ((req_valid[c] && !hs[c]) || $urandom_range(0, 99) >= 32'(gap_pct))) begin
          req_valid[c]        = 1'b1;
          req_data[c*DW +: DW] = src_q[c][0].data;
          req_last[c]         = src_q[c][0].last;
        end else begin
          req_valid[c]        = 1'b0;
          req_data[c*DW +: DW] = $urandom;
          req_last[c]         = 1'($urandom);
        end
        rsp_ready[c] = !rsp_block[c] && ($urandom_range(0, 99) < 32'(rsp_rdy_pct));
      end
      act_in_ready = $urandom_range(0, 99) < 32'(in_rdy_pct);
      if (force_out) begin
        act_out_valid = 1'b1;
        act_out_data  = $urandom;
      end else if (stage_q.size() > 0 &&
                   ((act_out_valid && !aout) || $urandom_range(0, 99) < 32'(out_vld_pct))) begin
        act_out_valid = 1'b1;
        act_out_data  = stage_q[0];
      end else begin
        act_out_valid = 1'b0;
        act_out_data  = $urandom;
      end
    end
  end

  // Monitor: reference arbitration + in-order response scoreboard.
  initial begin : monitor
    int             pre, cur_g, last_m;
    bit             idle_m, err_m;
    logic [NCH-1:0] acc, exp_rv, others;
    logic [DW-1:0]  d;
    exp_t           e;
    cur_g = 0; last_m = NCH - 1; idle_m = 1'b1; err_m = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("reset_outputs",
              64'({req_ready, act_in_valid, act_out_ready, rsp_valid, busy, grant_id, err}), 64'(0));
        exp_q.delete();
        grant_log.delete();
        for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
        rsp_cnt = 0; cur_g = 0; last_m = NCH - 1; idle_m = 1'b1; err_m = 1'b0;
      end else begin
        pre = exp_q.size();
        check("busy", 64'(busy), 64'(!idle_m || pre != 0));
        check("err", 64'(err), 64'(err_m));
        check("grant_id", 64'(grant_id), 64'(cur_g));
        // response side, against the oldest outstanding beat
        exp_rv = '0;
        if (pre != 0 && act_out_valid) exp_rv[exp_q[0].ch] = 1'b1;
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("act_out_ready", 64'(act_out_ready), 64'(pre != 0 && rsp_ready[exp_q[0].ch]));
        if (exp_rv != 0) begin
          check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
          if (rsp_ready[exp_q[0].ch]) begin
            void'(exp_q.pop_front());
            rsp_cnt++;
          end
        end
        if (act_out_valid && pre == 0) err_m = 1'b1;
        // request side
        acc = req_valid & req_ready;
        check("act_in_hs", 64'(act_in_valid && act_in_ready), 64'(acc != 0));
        if (idle_m) begin
          check("idle_no_accept", 64'({req_ready, act_in_valid}), 64'(0));
          if (req_valid != 0) begin
            cur_g  = rr_ref(req_valid, last_m);
            idle_m = 1'b0;
            grant_log.push_back(cur_g);
          end
        end else begin
          others = req_ready;
          others[cur_g] = 1'b0;
          check("ready_only_granted", 64'(others), 64'(0));
          if (pre >= MI) check("full_gate", 64'({req_ready[cur_g], act_in_valid}), 64'(0));
          if (acc[cur_g]) begin
            d      = req_data[cur_g*DW +: DW];
            e.ch   = cur_g;
            e.data = relu(d);
            exp_q.push_back(e);
            acc_cnt[cur_g]++;
            if (req_last[cur_g]) begin
              last_m = cur_g;
              idle_m = 1'b1;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    int total;
    rst_n = 1'b0;
    rsp_block = '0; force_out = 1'b0;
    gap_pct = 0; in_rdy_pct = 100; out_vld_pct = 100; rsp_rdy_pct = 100;
    repeat (3) @(negedge clk);
    release_reset();

    // single packet on ch1: ReLU of {-5, 7, min-int}
    push_beat(1, 32'hFFFF_FFFB, 1'b0);
    push_beat(1, 32'd7,         1'b0);
    push_beat(1, 32'h8000_0000, 1'b1);
    wait_drain("single_drain", 200);
    check("single_rsp_cnt", 64'(rsp_cnt), 64'(3));
    check("single_grant_id", 64'(grant_id), 64'(1));
    check("single_busy", 64'(busy), 64'(0));

    // contention from reset: ch0, ch2, ch3
    do_reset();
    push_pkt(0, 2); push_pkt(2, 2); push_pkt(3, 2);
    release_reset();
    wait_drain("contention_drain", 300);
    check_order("contention_order", 0, 2, 3);

    // fairness: ch0 re-requests at once, waiting ch3 goes first
    do_reset();
    push_pkt(0, 2); push_pkt(0, 2); push_pkt(3, 2);
    release_reset();
    wait_drain("fair_drain", 300);
    check_order("fair_order", 0, 3, 0);

    // tag FIFO full with ch0 responses blocked
    do_reset();
    rsp_block = 4'b0001;
    push_pkt(0, 8);
    release_reset();
    repeat (20) @(negedge clk);
    check("full_accepted", 64'(acc_cnt[0]), 64'(4));
    check("full_ready_low", 64'(req_ready[0]), 64'(0));
    check("full_valid_held", 64'(req_valid[0]), 64'(1));
    rsp_block = '0;
    wait_drain("full_drain", 300);
    check("full_total", 64'(acc_cnt[0]), 64'(8));
    check("full_rsp_cnt", 64'(rsp_cnt), 64'(8));

    // reset in the middle of a packet
    do_reset();
    release_reset();
    push_pkt(2, 5);
    n = 0;
    while (acc_cnt[2] < 2 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("midreset_progress", 64'(n < 100), 64'(1));
    reset_now();
    check("midreset_busy", 64'(busy), 64'(0));
    check("midreset_err", 64'(err), 64'(0));
    release_reset();
    push_pkt(2, 3);
    wait_drain("midreset_fresh_drain", 300);
    check("midreset_fresh_rsp", 64'(rsp_cnt), 64'(3));

    // randomized traffic across all channels
    do_reset();
    release_reset();
    gap_pct = 30; in_rdy_pct = 70; out_vld_pct = 70; rsp_rdy_pct = 70;
    total = 0;
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      push_pkt($urandom_range(0, NCH - 1), n);
      total += n;
    end
    wait_drain("random_drain", 20000);
    check("random_rsp_cnt", 64'(rsp_cnt), 64'(total));
    gap_pct = 0; in_rdy_pct = 100; out_vld_pct = 100; rsp_rdy_pct = 100;

    // protocol error: result with nothing outstanding
    @(posedge clk);
    #2;
    force_out = 1'b1;
    act_out_valid = 1'b1;
    @(negedge clk);
    check("perr_out_ready", 64'(act_out_ready), 64'(0));
    @(posedge clk);
    #2;
    force_out = 1'b0;
    repeat (2) @(negedge clk);
    check("perr_err_set", 64'(err), 64'(1));
    push_pkt(1, 2);
    wait_drain("perr_traffic_drain", 300);
    check("perr_err_sticky", 64'(err), 64'(1));
    do_reset();
    check("perr_err_cleared", 64'(err), 64'(0));
    release_reset();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
